fetch_arb: RTL and testbench
============================

FETCH_ARB -- requirements
Module: fetch_arb

Interface
REQ-001 Parameter addr_width, default 32, fetch line address width.
REQ-002 Parameter list_depth, default 4, line-list entries; tag width TW = $clog2(list_depth).
REQ-003 Parameter timeout_cycles, default 1024, maximum cycles allowed from issue to bus_done.
REQ-004 clk  in  1  single clock, all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rd_fetch_req / rd_fetch_cmd / rd_fetch_tag / rd_fetch_addr  in  1/2/TW/addr_width  read-controller fetch request and its fields.
REQ-007 rd_fetch_gnt  out  1  request accepted from the read controller.
REQ-008 rd_fetch_done  out  1  read-controller fetch complete, one-cycle pulse.
REQ-009 wr_fetch_req / wr_fetch_cmd / wr_fetch_tag / wr_fetch_addr  in  1/2/TW/addr_width  write-controller fetch request and its fields.
REQ-010 wr_fetch_gnt / wr_fetch_done  out  1/1  write-controller accept and completion pulse.
REQ-011 bus_req / bus_cmd / bus_tag / bus_addr  out  1/2/TW/addr_width  request to the single fetch engine.
REQ-012 bus_gnt / bus_done  in  1/1  fetch-engine accept and completion pulse.
REQ-013 busy  out  1  a transaction is issued or outstanding.
REQ-014 timeout_err  out  1  sticky flag set when timeout_cycles expires.

Function
REQ-015 The FSM has three states: IDLE, ISSUE and WAIT_DONE.
REQ-016 In IDLE with at least one request, the block grants one winner combinationally: x_fetch_gnt=1 in that cycle, fields latched, owner latched, next state ISSUE.
REQ-017 A single requester always wins.
REQ-018 With both requesting, the requester selected by the round-robin pointer rr wins; rr resets to write-priority (0=wr, 1=rd).
REQ-019 rr toggles to the non-owner when a transaction completes, i.e. on the bus_done accepted in WAIT_DONE.
REQ-020 At most one x_fetch_gnt is high per cycle, and only in IDLE.
REQ-021 In ISSUE, bus_req=1 and bus_cmd/tag/addr equal the latched fields, held stable until bus_gnt; ISSUE→WAIT_DONE on bus_gnt.
REQ-022 In WAIT_DONE, bus_done drives the owner's x_fetch_done=1 in the same cycle (combinational), then →IDLE.
REQ-023 Minimum turnaround: a new grant occurs no earlier than the cycle after done.
REQ-024 bus_done outside WAIT_DONE is ignored: no done pulse, no state change.
REQ-025 Requests arriving while not in IDLE are not granted and are not lost, since requesters hold req until gnt.
REQ-026 busy = (state != IDLE).
REQ-027 A timeout counter clears on entry to ISSUE, increments each cycle in ISSUE/WAIT_DONE, and saturates.
REQ-028 When the counter reaches timeout_cycles-1 without bus_done, timeout_err sets and stays set until reset; the FSM keeps waiting.
REQ-029 bus_done arriving in the same cycle as the counter reaching its limit counts as completion; timeout_err is not set.
REQ-030 Outputs are zero when inactive: bus_cmd/tag/addr read 0 outside ISSUE.

Reset
REQ-031 On rst_n low, state=IDLE, rr=0, latched fields=0, owner=0, counter=0, timeout_err=0.
REQ-032 During reset, all gnt/done/bus_req outputs are 0 and busy=0.
REQ-033 Reset asserted mid-transaction abandons the transaction with no done pulse emitted.

Structure
REQ-034 The FSM state enum, the fetch cmd encodings (00 write-back, 01 fill) and the owner encoding live in a shared package, cache_pkg.
REQ-035 The two-requester round-robin selector is one sub-module, rr_arb2, with inputs req[1:0] and ptr and a one-hot gnt[1:0] output.
REQ-036 The total implementation is 120-400 RTL lines.

Verification
REQ-037 Single rd request (addr 0x1000, tag 2, cmd 01), bus_gnt after 3 cycles, bus_done after 5 more -> rd_fetch_gnt pulses in the first cycle, bus_addr=0x1000 held until gnt, rd_fetch_done pulses once, wr outputs stay 0.
REQ-038 rd and wr requesting together from reset, each completing -> wr is granted first, then rd; a second simultaneous pair is granted wr, rd again (alternation).
REQ-039 wr request held during an outstanding rd transaction -> no wr_fetch_gnt until the cycle after rd_fetch_done, then wr is granted.
REQ-040 timeout_cycles=8 with bus_done withheld -> timeout_err=1 at cycle 8 after ISSUE entry; a later bus_done still pulses done, and timeout_err stays 1.
REQ-041 rst_n asserted in WAIT_DONE, then bus_done after reset release -> no done pulse, state IDLE, busy=0.
REQ-042 Spurious bus_done in IDLE -> no output change.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: definitions shared by the fetch arbiter and its testbench.
//   fsm_state_t : arbiter FSM states (IDLE / ISSUE / WAIT_DONE)
//   owner_t     : which controller owns the current transaction (0=wr, 1=rd)
//   CMD_*       : fetch command encodings carried on *_fetch_cmd / bus_cmd
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } fsm_state_t;

    typedef enum logic {
        OWN_WR = 1'b0,
        OWN_RD = 1'b1
    } owner_t;

    localparam logic [1:0] CMD_WB   = 2'b00;  // write-back
    localparam logic [1:0] CMD_FILL = 2'b01;  // line fill

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin selector (purely combinational).
//   req[1:0] : request vector (bit 0 = wr, bit 1 = rd)
//   ptr      : priority pointer, index of the requester that wins a tie
//   gnt[1:0] : one-hot grant (all zero when nothing is requested)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[0] && req[1]) begin
            gnt[ptr] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/fetch_arb.sv
// fetch_arb: arbitrates read- and write-controller fetch requests onto a
// single fetch engine, one transaction at a time.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rd_fetch_* / wr_fetch_*    : requester ports (req/cmd/tag/addr in, gnt/done out)
//   bus_req/cmd/tag/addr       : request to the fetch engine (valid only in ISSUE)
//   bus_gnt, bus_done          : engine accept and completion pulse
//   busy                       : a transaction is issued or outstanding
//   timeout_err                : sticky, set when a transaction exceeds timeout_cycles
module fetch_arb
    import cache_pkg::*;
#(
    parameter int addr_width     = 32,
    parameter int list_depth     = 4,
    parameter int timeout_cycles = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          rd_fetch_req,
    input  logic [1:0]                    rd_fetch_cmd,
    input  logic [$clog2(list_depth)-1:0] rd_fetch_tag,
    input  logic [addr_width-1:0]         rd_fetch_addr,
    output logic                          rd_fetch_gnt,
    output logic                          rd_fetch_done,

    input  logic                          wr_fetch_req,
    input  logic [1:0]                    wr_fetch_cmd,
    input  logic [$clog2(list_depth)-1:0] wr_fetch_tag,
    input  logic [addr_width-1:0]         wr_fetch_addr,
    output logic                          wr_fetch_gnt,
    output logic                          wr_fetch_done,

    output logic                          bus_req,
    output logic [1:0]                    bus_cmd,
    output logic [$clog2(list_depth)-1:0] bus_tag,
    output logic [addr_width-1:0]         bus_addr,
    input  logic                          bus_gnt,
    input  logic                          bus_done,

    output logic                          busy,
    output logic                          timeout_err
);

    localparam int TW = $clog2(list_depth);
    localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(timeout_cycles - 1);

    fsm_state_t          r_state;
    logic                r_rr;
    owner_t              r_owner;
    logic [1:0]          r_cmd;
    logic [TW-1:0]       r_tag;
    logic [addr_width-1:0] r_addr;
    logic [CW-1:0]       r_cnt;
    logic                r_timeout_err;

    logic [1:0]          w_req;
    logic [1:0]          w_arb_gnt;
    logic [1:0]          w_gnt;
    logic                w_done;

    assign w_req = {rd_fetch_req, wr_fetch_req};

    rr_arb2 u_rr_arb2 (
        .req (w_req),
        .ptr (r_rr),
        .gnt (w_arb_gnt)
    );

    // Grants exist only in IDLE; rst_n gating keeps them low while reset is held
    // even though the reset state itself is IDLE.
    assign w_gnt  = (rst_n && (r_state == ST_IDLE)) ? w_arb_gnt : 2'b00;
    assign w_done = (r_state == ST_WAIT_DONE) && bus_done;

    assign wr_fetch_gnt  = w_gnt[0];
    assign rd_fetch_gnt  = w_gnt[1];
    assign wr_fetch_done = w_done && (r_owner == OWN_WR);
    assign rd_fetch_done = w_done && (r_owner == OWN_RD);

    assign bus_req     = (r_state == ST_ISSUE);
    assign bus_cmd     = bus_req ? r_cmd  : '0;
    assign bus_tag     = bus_req ? r_tag  : '0;
    assign bus_addr    = bus_req ? r_addr : '0;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr          <= 1'b0;
            r_owner       <= OWN_WR;
            r_cmd         <= '0;
            r_tag         <= '0;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_owner <= w_gnt[1] ? OWN_RD : OWN_WR;
                        r_cmd   <= w_gnt[1] ? rd_fetch_cmd  : wr_fetch_cmd;
                        r_tag   <= w_gnt[1] ? rd_fetch_tag  : wr_fetch_tag;
                        r_addr  <= w_gnt[1] ? rd_fetch_addr : wr_fetch_addr;
                        r_cnt   <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus_gnt) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus_done) begin
                        r_state <= ST_IDLE;
                        // Hand priority to whichever controller did not own this one.
                        r_rr    <= (r_owner == OWN_WR);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (r_state != ST_IDLE) begin
                if (r_cnt != CNT_LIMIT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                // A completion landing on the limit cycle still counts as on time.
                if ((r_cnt == CNT_LIMIT) && !w_done) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_arb.sv
module tb_fetch_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_fetch_req = 1'b0;
    logic [1:0]  rd_fetch_cmd = '0;
    logic [1:0]  rd_fetch_tag = '0;
    logic [31:0] rd_fetch_addr = '0;
    logic        rd_fetch_gnt, rd_fetch_done;
    logic        wr_fetch_req = 1'b0;
    logic [1:0]  wr_fetch_cmd = '0;
    logic [1:0]  wr_fetch_tag = '0;
    logic [31:0] wr_fetch_addr = '0;
    logic        wr_fetch_gnt, wr_fetch_done;
    logic        bus_req;
    logic [1:0]  bus_cmd;
    logic [1:0]  bus_tag;
    logic [31:0] bus_addr;
    logic        bus_gnt = 1'b0;
    logic        bus_done = 1'b0;
    logic        busy, timeout_err;

    typedef struct {
        logic        own;   // 0 = wr, 1 = rd
        logic [1:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    logic m_rr = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_arb #(
        .addr_width     (32),
        .list_depth     (4),
        .timeout_cycles (8)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_fetch_req  (rd_fetch_req),
        .rd_fetch_cmd  (rd_fetch_cmd),
        .rd_fetch_tag  (rd_fetch_tag),
        .rd_fetch_addr (rd_fetch_addr),
        .rd_fetch_gnt  (rd_fetch_gnt),
        .rd_fetch_done (rd_fetch_done),
        .wr_fetch_req  (wr_fetch_req),
        .wr_fetch_cmd  (wr_fetch_cmd),
        .wr_fetch_tag  (wr_fetch_tag),
        .wr_fetch_addr (wr_fetch_addr),
        .wr_fetch_gnt  (wr_fetch_gnt),
        .wr_fetch_done (wr_fetch_done),
        .bus_req       (bus_req),
        .bus_cmd       (bus_cmd),
        .bus_tag       (bus_tag),
        .bus_addr      (bus_addr),
        .bus_gnt       (bus_gnt),
        .bus_done      (bus_done),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic own, input logic [1:0] cmd,
                             input logic [1:0] tag, input logic [31:0] addr);
        exp_t e;
        if (own) begin
            rd_fetch_req = 1'b1; rd_fetch_cmd = cmd; rd_fetch_tag = tag; rd_fetch_addr = addr;
        end else begin
            wr_fetch_req = 1'b1; wr_fetch_cmd = cmd; wr_fetch_tag = tag; wr_fetch_addr = addr;
        end
        e.own = own; e.cmd = cmd; e.tag = tag; e.addr = addr;
        sb.push_back(e);
    endtask

    // Requester drops req after its grant; fields are cleared so the DUT must hold latched copies.
    task automatic drop(input logic own);
        if (own) begin
            rd_fetch_req = 1'b0; rd_fetch_cmd = '0; rd_fetch_tag = '0; rd_fetch_addr = '0;
        end else begin
            wr_fetch_req = 1'b0; wr_fetch_cmd = '0; wr_fetch_tag = '0; wr_fetch_addr = '0;
        end
    endtask

    // Entered at the start of the first ISSUE cycle; returns at the negedge of the first IDLE cycle.
    task automatic serve(input int gd, input int dd, input logic exp_err);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c <= gd; c++) begin
            bus_gnt = (c == gd);
            @(negedge clk);
            chk("issue_busy", busy, 1);
            chk("issue_bus_req", bus_req, 1);
            chk("issue_bus_cmd", bus_cmd, e.cmd);
            chk("issue_bus_tag", bus_tag, e.tag);
            chk("issue_bus_addr", bus_addr, e.addr);
            chk("issue_no_gnt", {rd_fetch_gnt, wr_fetch_gnt}, 0);
            chk("issue_no_done", {rd_fetch_done, wr_fetch_done}, 0);
            tick();
        end
        bus_gnt = 1'b0;
        for (int c = 0; c <= dd; c++) begin
            bus_done = (c == dd);
            @(negedge clk);
            chk("wait_busy", busy, 1);
            chk("wait_bus_req", bus_req, 0);
            chk("wait_bus_addr", bus_addr, 0);
            chk("wait_no_gnt", {rd_fetch_gnt, wr_fetch_gnt}, 0);
            chk("wait_rd_done", rd_fetch_done, (c == dd) && e.own);
            chk("wait_wr_done", wr_fetch_done, (c == dd) && !e.own);
            tick();
        end
        bus_done = 1'b0;
        m_rr = ~e.own;
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_timeout_err", timeout_err, exp_err);
        chk("post_no_done", {rd_fetch_done, wr_fetch_done}, 0);
    endtask

    task automatic pair(input logic [31:0] a_wr, input logic [31:0] a_rd);
        logic first;
        first = m_rr;
        tick();
        drive_req(first, first ? 2'b01 : 2'b00, first ? 2'd1 : 2'd0, first ? a_rd : a_wr);
        drive_req(~first, first ? 2'b00 : 2'b01, first ? 2'd0 : 2'd1, first ? a_wr : a_rd);
        @(negedge clk);
        chk("pair_gnt_first", {rd_fetch_gnt, wr_fetch_gnt}, first ? 2'b10 : 2'b01);
        tick();
        drop(first);
        serve(1, 1, 1'b0);
        chk("pair_gnt_second", {rd_fetch_gnt, wr_fetch_gnt}, first ? 2'b01 : 2'b10);
        tick();
        drop(~first);
        serve(0, 2, 1'b0);
    endtask

    initial begin
        exp_t e;

        // Reset held with both requesters active: nothing may be granted.
        rd_fetch_req = 1'b1; rd_fetch_addr = 32'hDEAD_0000;
        wr_fetch_req = 1'b1; wr_fetch_addr = 32'hBEEF_0000;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {rd_fetch_gnt, wr_fetch_gnt}, 0);
        chk("rst_done", {rd_fetch_done, wr_fetch_done}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_fields", {bus_cmd, bus_tag, bus_addr}, 0);
        chk("rst_timeout_err", timeout_err, 0);
        tick();
        drop(1'b0);
        drop(1'b1);
        tick();
        rst_n = 1'b1;

        // Simultaneous pairs from reset: wr, rd, then wr, rd again.
        m_rr = 1'b0;
        pair(32'h0000_A000, 32'h0000_B000);
        pair(32'h0000_A100, 32'h0000_B100);

        // Spurious bus_done in IDLE.
        tick();
        bus_done = 1'b1;
        @(negedge clk);
        chk("spur_done", {rd_fetch_done, wr_fetch_done}, 0);
        chk("spur_busy", busy, 0);
        chk("spur_bus_req", bus_req, 0);
        tick();
        bus_done = 1'b0;
        @(negedge clk);
        chk("spur_busy_after", busy, 0);

        // Single rd; bus_done lands exactly on the timeout limit cycle.
        tick();
        drive_req(1'b1, 2'b01, 2'd2, 32'h0000_1000);
        @(negedge clk);
        chk("single_gnt", {rd_fetch_gnt, wr_fetch_gnt}, 2'b10);
        chk("single_busy_idle", busy, 0);
        tick();
        drop(1'b1);
        serve(2, 4, 1'b0);

        // wr held during an outstanding rd: granted only after rd completes.
        tick();
        drive_req(1'b1, 2'b01, 2'd3, 32'h0000_3000);
        @(negedge clk);
        chk("hold_rd_gnt", {rd_fetch_gnt, wr_fetch_gnt}, 2'b10);
        tick();
        drop(1'b1);
        drive_req(1'b0, 2'b00, 2'd1, 32'h0000_4000);
        serve(1, 2, 1'b0);
        chk("hold_wr_gnt", {rd_fetch_gnt, wr_fetch_gnt}, 2'b01);
        tick();
        drop(1'b0);
        serve(0, 0, 1'b0);

        // Last completion was wr, so a new tie goes to rd first.
        pair(32'h0000_C000, 32'h0000_D000);

        // Timeout: bus_done withheld past the limit.
        tick();
        drive_req(1'b0, 2'b00, 2'd3, 32'h0000_BEE0);
        @(negedge clk);
        chk("to_gnt", {rd_fetch_gnt, wr_fetch_gnt}, 2'b01);
        tick();
        drop(1'b0);
        bus_gnt = 1'b1;
        e = sb.pop_front();
        @(negedge clk);
        chk("to_bus_addr", bus_addr, e.addr);
        tick();
        bus_gnt = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("to_err_edge", timeout_err, (k >= 8));
            chk("to_busy", busy, 1);
            tick();
        end
        bus_done = 1'b1;
        @(negedge clk);
        chk("to_late_wr_done", wr_fetch_done, 1);
        chk("to_late_rd_done", rd_fetch_done, 0);
        tick();
        bus_done = 1'b0;
        m_rr = 1'b1;
        @(negedge clk);
        chk("to_busy_after", busy, 0);
        chk("to_err_sticky", timeout_err, 1);

        // Reset asserted in WAIT_DONE abandons the transaction.
        tick();
        drive_req(1'b1, 2'b01, 2'd1, 32'h0000_2000);
        @(negedge clk);
        chk("mid_gnt", {rd_fetch_gnt, wr_fetch_gnt}, 2'b10);
        tick();
        drop(1'b1);
        bus_gnt = 1'b1;
        @(negedge clk);
        tick();
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("mid_busy_wait", busy, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", timeout_err, 0);
        chk("mid_rst_done", {rd_fetch_done, wr_fetch_done}, 0);
        chk("mid_rst_bus_req", bus_req, 0);
        void'(sb.pop_front());
        m_rr = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus_done = 1'b1;
        @(negedge clk);
        chk("mid_late_done", {rd_fetch_done, wr_fetch_done}, 0);
        chk("mid_late_busy", busy, 0);
        tick();
        bus_done = 1'b0;
        @(negedge clk);
        chk("mid_idle_busy", busy, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
